// File: rtl/mem_bus_arbiter_if.sv
// Bundles the two CPU request ports, the shared response and the memory
// controller side of mem_bus_arbiter. The arbiter uses the slave modport.
interface mem_bus_arbiter_if;
    logic        req0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        we0;
    logic        ack0;

    logic        req1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        we1;
    logic        ack1;

    logic [31:0] rdata;
    logic        err;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_is_write;
    logic        mem_start;
    logic        mem_busy;
    logic [31:0] mem_rdata;

    modport slave (
        input  req0, addr0, wdata0, we0,
        input  req1, addr1, wdata1, we1,
        input  mem_busy, mem_rdata,
        output ack0, ack1, rdata, err,
        output mem_addr, mem_wdata, mem_is_write, mem_start
    );

    modport master (
        output req0, addr0, wdata0, we0,
        output req1, addr1, wdata1, we1,
        output mem_busy, mem_rdata,
        input  ack0, ack1, rdata, err,
        input  mem_addr, mem_wdata, mem_is_write, mem_start
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory controller port between the
// instruction-fetch port (0) and the data port (1), with a busy timeout.
module mem_bus_arbiter #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_bus_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        ACK
    } state_t;

    state_t             state;
    logic               last_grant;
    logic               cur;
    logic [CNT_W-1:0]   cnt;
    logic               grant_port;

    // Under contention the port that did not win last time goes next.
    assign grant_port = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            last_grant       <= 1'b1;
            cur              <= 1'b0;
            cnt              <= '0;
            bus.ack0         <= 1'b0;
            bus.ack1         <= 1'b0;
            bus.rdata        <= '0;
            bus.err          <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_wdata    <= '0;
            bus.mem_is_write <= 1'b0;
            bus.mem_start    <= 1'b0;
        end else begin
            bus.mem_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        cur              <= grant_port;
                        bus.mem_addr     <= grant_port ? bus.addr1  : bus.addr0;
                        bus.mem_wdata    <= grant_port ? bus.wdata1 : bus.wdata0;
                        bus.mem_is_write <= grant_port ? bus.we1    : bus.we0;
                        bus.mem_start    <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // A stuck controller is abandoned with err and zero data.
                    if (!bus.mem_busy) begin
                        bus.rdata <= bus.mem_rdata;
                        bus.err   <= 1'b0;
                        bus.ack0  <= ~cur;
                        bus.ack1  <= cur;
                        state     <= ACK;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        bus.rdata <= '0;
                        bus.err   <= 1'b1;
                        bus.ack0  <= ~cur;
                        bus.ack1  <= cur;
                        state     <= ACK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ACK: begin
                    bus.ack0   <= 1'b0;
                    bus.ack1   <= 1'b0;
                    bus.rdata  <= '0;
                    bus.err    <= 1'b0;
                    last_grant <= cur;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small busy-latency controller model.
module tb_mem_bus_arbiter;

    logic clk;
    logic rst_n;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Controller model: busy for lat cycles after a start, or forever while stuck.
    int lat = 0;
    bit stuck = 0;
    int rem;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_busy <= 1'b0;
            rem          <= 0;
        end else if (bus.mem_start) begin
            bus.mem_busy <= stuck || (lat > 0);
            rem          <= lat;
        end else if (!stuck) begin
            if (rem <= 1) bus.mem_busy <= 1'b0;
            else          rem <= rem - 1;
        end
    end

    int ack_events = 0;
    int both_acks = 0;
    always @(negedge clk) begin
        if (bus.ack0 || bus.ack1) ack_events++;
        if (bus.ack0 && bus.ack1) both_acks++;
    end

    int          start_j, ack_j, n_starts;
    logic        saw_ack0, saw_ack1, ack_err;
    logic [31:0] ack_rdata, seen_addr, seen_wdata;
    logic        seen_we;
    bit          hold_ok;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input int port, input logic we,
                                  input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end
    endtask

    // Follows one access from the current falling edge until its ack (bounded).
    task automatic wait_access();
        start_j = 0; ack_j = 0; n_starts = 0; hold_ok = 1;
        saw_ack0 = 0; saw_ack1 = 0; ack_err = 0; ack_rdata = '0;
        for (int j = 1; j <= 40 && ack_j == 0; j++) begin
            @(negedge clk);
            if (bus.mem_start) begin
                n_starts++;
                if (start_j == 0) begin
                    start_j    = j;
                    seen_addr  = bus.mem_addr;
                    seen_wdata = bus.mem_wdata;
                    seen_we    = bus.mem_is_write;
                end
            end else if (start_j != 0 && (bus.mem_addr !== seen_addr ||
                         bus.mem_wdata !== seen_wdata || bus.mem_is_write !== seen_we)) begin
                hold_ok = 0;
            end
            if (bus.ack0 || bus.ack1) begin
                ack_j     = j;
                saw_ack0  = bus.ack0;
                saw_ack1  = bus.ack1;
                ack_rdata = bus.rdata;
                ack_err   = bus.err;
            end
        end
        check_output("ack_seen", 32'(ack_j != 0), 32'd1);
    endtask

    int snap;

    initial begin
        rst_n = 1'b0;
        bus.req0 = 0; bus.addr0 = '0; bus.wdata0 = '0; bus.we0 = 0;
        bus.req1 = 0; bus.addr1 = '0; bus.wdata1 = '0; bus.we1 = 0;
        bus.mem_rdata = 32'hA5A5A5A5;

        // Reset held with a pending request
        apply_stimulus(0, 1'b0, 32'h00000100, 32'h0);
        repeat (3) @(negedge clk);
        check_output("rst_mem_start", 32'(bus.mem_start), 32'd0);
        check_output("rst_mem_addr", bus.mem_addr, 32'd0);
        check_output("rst_ack0", 32'(bus.ack0), 32'd0);
        check_output("rst_rdata", bus.rdata, 32'd0);
        check_output("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        wait_access();
        check_output("rel_start_j", 32'(start_j), 32'd1);
        check_output("rel_addr", seen_addr, 32'h00000100);
        check_output("rel_ack_j", 32'(ack_j), 32'd3);
        check_output("rel_rdata", ack_rdata, 32'hA5A5A5A5);
        bus.req0 = 0;
        @(negedge clk);
        check_output("rel_ack_pulse", 32'(bus.ack0), 32'd0);

        // Single read on port 0, controller busy 3 cycles
        lat = 3; bus.mem_rdata = 32'hDEADBEEF;
        apply_stimulus(0, 1'b0, 32'h00000040, 32'h0);
        wait_access();
        check_output("rd_start_j", 32'(start_j), 32'd1);
        check_output("rd_ack_j", 32'(ack_j), 32'd6);
        check_output("rd_starts", 32'(n_starts), 32'd1);
        check_output("rd_is_write", 32'(seen_we), 32'd0);
        check_output("rd_ack0", 32'(saw_ack0), 32'd1);
        check_output("rd_ack1", 32'(saw_ack1), 32'd0);
        check_output("rd_rdata", ack_rdata, 32'hDEADBEEF);
        check_output("rd_err", 32'(ack_err), 32'd0);
        bus.req0 = 0;
        @(negedge clk);
        check_output("rd_ack_pulse", 32'(bus.ack0), 32'd0);

        // Single write on port 1
        lat = 2;
        apply_stimulus(1, 1'b1, 32'h80000010, 32'h12345678);
        wait_access();
        check_output("wr_is_write", 32'(seen_we), 32'd1);
        check_output("wr_addr", seen_addr, 32'h80000010);
        check_output("wr_wdata", seen_wdata, 32'h12345678);
        check_output("wr_hold", 32'(hold_ok), 32'd1);
        check_output("wr_ack1", 32'(saw_ack1), 32'd1);
        check_output("wr_ack0", 32'(saw_ack0), 32'd0);
        check_output("wr_ack_j", 32'(ack_j), 32'd5);
        bus.req1 = 0; bus.we1 = 0;
        @(negedge clk);

        // Contention: both ports keep requesting, grants alternate from port 0
        lat = 1;
        apply_stimulus(0, 1'b0, 32'h00001000, 32'h0);
        apply_stimulus(1, 1'b0, 32'h00002000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            wait_access();
            check_output($sformatf("cont_grant%0d", i), 32'(saw_ack1), 32'(i % 2));
            check_output($sformatf("cont_addr%0d", i), seen_addr,
                         (i % 2 == 0) ? 32'h00001000 : 32'h00002000);
        end
        bus.req0 = 0; bus.req1 = 0;
        @(negedge clk);

        // Timeout with the controller stuck busy, then a normal access
        stuck = 1; bus.mem_rdata = 32'hFFFF0000;
        apply_stimulus(0, 1'b0, 32'h00000300, 32'h0);
        wait_access();
        check_output("to_ack_j", 32'(ack_j), 32'd10);
        check_output("to_err", 32'(ack_err), 32'd1);
        check_output("to_rdata", ack_rdata, 32'd0);
        check_output("to_ack0", 32'(saw_ack0), 32'd1);
        bus.req0 = 0; stuck = 0;
        @(negedge clk);
        lat = 1; bus.mem_rdata = 32'h0BADF00D;
        apply_stimulus(0, 1'b0, 32'h00000304, 32'h0);
        wait_access();
        check_output("post_to_ack_j", 32'(ack_j), 32'd4);
        check_output("post_to_err", 32'(ack_err), 32'd0);
        check_output("post_to_rdata", ack_rdata, 32'h0BADF00D);
        bus.req0 = 0;
        @(negedge clk);

        // Reset pulsed during WAIT_DONE; port 0 must win right after release
        lat = 5;
        apply_stimulus(0, 1'b1, 32'h00000500, 32'h00000055);
        repeat (3) @(negedge clk);
        check_output("mid_is_write", 32'(bus.mem_is_write), 32'd1);
        snap = ack_events;
        #2 rst_n = 1'b0;
        #1;
        check_output("mid_async_addr", bus.mem_addr, 32'd0);
        check_output("mid_async_write", 32'(bus.mem_is_write), 32'd0);
        apply_stimulus(1, 1'b0, 32'h00000600, 32'h0);
        bus.we0 = 0;
        repeat (3) @(negedge clk);
        check_output("mid_no_ack", 32'(ack_events), 32'(snap));
        lat = 0; bus.mem_rdata = 32'h13572468;
        rst_n = 1'b1;
        wait_access();
        check_output("mid_first_port0", 32'(saw_ack0), 32'd1);
        check_output("mid_first_addr", seen_addr, 32'h00000500);
        check_output("mid_ack_j", 32'(ack_j), 32'd3);
        bus.req0 = 0; bus.req1 = 0;
        @(negedge clk);

        check_output("never_two_acks", 32'(both_acks), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
